// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// forwarding-mux select codes, scoreboard entry layout and match helper.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN,
        STALL,
        FLUSH
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic [4:0] dest;
    } sb_entry_t;

    // $0 is hardwired to zero, so a write to it never creates a dependency.
    function automatic logic sb_match(
        input sb_entry_t  e,
        input logic [4:0] r
    );
        return e.valid & e.reg_write &
               (e.dest == r) & (r != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shadow copy of the EX/MEM/WB destination fields, shifted in lockstep with
// the datapath buffers, plus per-stage source-register match flags.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   id_valid_i            IF/ID holds a real instruction
//   id_reg_write_i        ID instruction writes a register
//   id_mem_read_i         ID instruction is a load
//   id_dest_i             ID destination register
//   bubble_i              ID/EX loads a bubble this cycle
//   kill_i                taken branch: wrong-path EX instruction dies
//   rs_i, rt_i            ID source registers to compare
//   match_rs_o/match_rt_o [0]=EX [1]=MEM [2]=WB match
//   ex_mem_read_o         EX entry is a load
module hazard_scoreboard (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid_i,
    input  logic       id_reg_write_i,
    input  logic       id_mem_read_i,
    input  logic [4:0] id_dest_i,
    input  logic       bubble_i,
    input  logic       kill_i,
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    output logic [2:0] match_rs_o,
    output logic [2:0] match_rt_o,
    output logic       ex_mem_read_o
);
    import hazard_pkg::*;

    sb_entry_t ex_q, mem_q, wb_q;
    sb_entry_t ex_d, mem_d;
    logic      unused_wb_mr;

    always_comb begin
        ex_d = '0;
        if (id_valid_i && !bubble_i) begin
            ex_d.valid     = 1'b1;
            ex_d.reg_write = id_reg_write_i;
            ex_d.mem_read  = id_mem_read_i;
            ex_d.dest      = id_dest_i;
        end
        // The EX instruction moving into MEM is the wrong-path one.
        mem_d = kill_i ? '0 : ex_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= mem_q;
        end
    end

    assign match_rs_o = {sb_match(wb_q, rs_i),
                         sb_match(mem_q, rs_i),
                         sb_match(ex_q, rs_i)};
    assign match_rt_o = {sb_match(wb_q, rt_i),
                         sb_match(mem_q, rt_i),
                         sb_match(ex_q, rt_i)};

    assign ex_mem_read_o = ex_q.mem_read;
    assign unused_wb_mr  = wb_q.mem_read;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: RAW stalls,
// ID/EX bubbles and taken-branch flushes. Optional macro: FORWARDING_EN.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   id_valid, id_rs, id_rt     ID instruction and its sources
//   id_uses_rs, id_uses_rt     source-read qualifiers
//   id_reg_write, id_mem_read  ID writes a register / is a load
//   id_dest                    ID destination (after RegDst)
//   br_taken                   branch resolved taken in MEM
//   pc_en, if_id_en            PC / buffer1 load enables
//   if_id_flush                buffer1 loads NOP
//   id_ex_bubble               buffer2 loads zero control
//   ex_mem_flush               buffer3 loads zero control
//   fwd_a, fwd_b               ALU operand source (EX aligned)
//   stall_cnt                  saturating stall-cycle count
module hazard_ctrl #(
    parameter int CNT_W     = 16,
    parameter int WB_HAZARD = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic [4:0]       id_dest,
    input  logic             br_taken,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);
    import hazard_pkg::*;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       m_rs, m_rt;
    logic             ex_mr;
    logic             hazard;
    logic             stall;

    hazard_scoreboard u_sb (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid_i     (id_valid),
        .id_reg_write_i (id_reg_write),
        .id_mem_read_i  (id_mem_read),
        .id_dest_i      (id_dest),
        .bubble_i       (id_ex_bubble),
        .kill_i         (br_taken),
        .rs_i           (id_rs),
        .rt_i           (id_rt),
        .match_rs_o     (m_rs),
        .match_rt_o     (m_rt),
        .ex_mem_read_o  (ex_mr)
    );

`ifdef FORWARDING_EN
    logic [1:0] fa_d, fb_d, fa_q, fb_q;
    logic       unused_fwd;

    // Only a load in EX cannot be bypassed in time.
    assign hazard = id_valid & ex_mr &
                    ((id_uses_rs & m_rs[0]) |
                     (id_uses_rt & m_rt[0]));

    // EX producer reaches EX/MEM, MEM producer reaches
    // MEM/WB by the time the consumer is in EX.
    always_comb begin
        fa_d = FWD_RF;
        fb_d = FWD_RF;
        if (id_valid && id_uses_rs) begin
            if (m_rs[0])      fa_d = FWD_MEM;
            else if (m_rs[1]) fa_d = FWD_WB;
        end
        if (id_valid && id_uses_rt) begin
            if (m_rt[0])      fb_d = FWD_MEM;
            else if (m_rt[1]) fb_d = FWD_WB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fa_q <= FWD_RF;
            fb_q <= FWD_RF;
        end else begin
            fa_q <= id_ex_bubble ? FWD_RF : fa_d;
            fb_q <= id_ex_bubble ? FWD_RF : fb_d;
        end
    end

    assign fwd_a      = fa_q;
    assign fwd_b      = fb_q;
    assign unused_fwd = m_rs[2] ^ m_rt[2] ^
                        (WB_HAZARD != 0);
`else
    logic [2:0] stage_mask;
    logic       unused_ex_mr;

    assign stage_mask = {(WB_HAZARD != 0), 2'b11};
    assign hazard = id_valid &
                    ((id_uses_rs & |(m_rs & stage_mask)) |
                     (id_uses_rt & |(m_rt & stage_mask)));

    assign fwd_a        = FWD_RF;
    assign fwd_b        = FWD_RF;
    assign unused_ex_mr = ex_mr;
`endif

    always_comb begin
        state_d      = state_q;
        stall        = 1'b0;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_flush = 1'b0;
        if (br_taken) begin
            state_d      = FLUSH;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
        end else begin
            case (state_q)
                RUN, STALL: begin
                    if (hazard) begin
                        state_d      = STALL;
                        stall        = 1'b1;
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_bubble = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                // Wrong-path entries were already killed.
                FLUSH:   state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: RAW/load-use stalls, $0, branch flush,
// async reset and counter saturation (second instance with CNT_W=2).
module tb_hazard_ctrl;

`ifdef FORWARDING_EN
    localparam int         RAW_ST = 0;
    localparam int         LU_ST  = 1;
    localparam int         B2B_ST = 0;
    localparam logic [1:0] FA_RAW = 2'b01;
    localparam logic [1:0] FA_LU  = 2'b10;
    localparam logic [1:0] FA_B2B = 2'b10;
`else
    localparam int         RAW_ST = 3;
    localparam int         LU_ST  = 3;
    localparam int         B2B_ST = 2;
    localparam logic [1:0] FA_RAW = 2'b00;
    localparam logic [1:0] FA_LU  = 2'b00;
    localparam logic [1:0] FA_B2B = 2'b00;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_uses_rs, id_uses_rt;
    logic        id_reg_write, id_mem_read, br_taken;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic        pc_en, if_id_en, if_id_flush;
    logic        id_ex_bubble, ex_mem_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;
    logic        s_pc_en, s_if_id_en, s_if_id_flush;
    logic        s_id_ex_bubble, s_ex_mem_flush;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [1:0]  s_stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_dest(id_dest), .br_taken(br_taken),
        .pc_en(pc_en), .if_id_en(if_id_en),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .ex_mem_flush(ex_mem_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_dest(id_dest), .br_taken(br_taken),
        .pc_en(s_pc_en), .if_id_en(s_if_id_en),
        .if_id_flush(s_if_id_flush), .id_ex_bubble(s_id_ex_bubble),
        .ex_mem_flush(s_ex_mem_flush),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt)
    );

    task automatic drv(input logic v, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urs,
                       input logic urt, input logic rw,
                       input logic mr, input logic [4:0] dst);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rs   = urs;
        id_uses_rt   = urt;
        id_reg_write = rw;
        id_mem_read  = mr;
        id_dest      = dst;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        br_taken = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        br_taken = 1'b0;
        drv(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3);
        #3;
        checks++;
        if ({pc_en, if_id_en, if_id_flush, id_ex_bubble,
             ex_mem_flush} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 11000",
                     {pc_en, if_id_en, if_id_flush,
                      id_ex_bubble, ex_mem_flush});
        end
        checks++;
        if ({fwd_a, fwd_b} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_fwd: got %b want 0000",
                     {fwd_a, fwd_b});
        end
        checks++;
        if (stall_cnt !== 16'd0 || s_stall_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d/%0d want 0/0",
                     stall_cnt, s_stall_cnt);
        end
        @(negedge clk);
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_raw();
        logic e;
        do_reset();
        @(negedge clk);
        drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
        #1;
        checks++;
        if (pc_en !== 1'b1) begin
            errors++;
            $display("FAIL raw_prod pc_en: got %b want 1", pc_en);
        end
        for (int c = 0; c <= RAW_ST; c++) begin
            @(negedge clk);
            drv(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
            #1;
            e = (c < RAW_ST);
            checks++;
            if ({pc_en, if_id_en, id_ex_bubble} !== {~e, ~e, e}) begin
                errors++;
                $display("FAIL raw_cyc%0d: got %b want %b", c,
                         {pc_en, if_id_en, id_ex_bubble},
                         {~e, ~e, e});
            end
        end
        checks++;
        if (stall_cnt !== 16'(RAW_ST)) begin
            errors++;
            $display("FAIL raw_cnt: got %0d want %0d",
                     stall_cnt, RAW_ST);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (fwd_a !== FA_RAW || fwd_b !== 2'b00) begin
            errors++;
            $display("FAIL raw_fwd: got %b/%b want %b/00",
                     fwd_a, fwd_b, FA_RAW);
        end
    endtask

    task automatic test_load_use();
        logic e;
        do_reset();
        @(negedge clk);
        drv(1'b1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
        for (int c = 0; c <= LU_ST; c++) begin
            @(negedge clk);
            drv(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
            #1;
            e = (c < LU_ST);
            checks++;
            if ({pc_en, id_ex_bubble} !== {~e, e}) begin
                errors++;
                $display("FAIL lu_cyc%0d: got %b want %b", c,
                         {pc_en, id_ex_bubble}, {~e, e});
            end
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (fwd_a !== FA_LU || fwd_b !== FA_LU) begin
            errors++;
            $display("FAIL lu_fwd: got %b/%b want %b/%b",
                     fwd_a, fwd_b, FA_LU, FA_LU);
        end
        checks++;
        if (stall_cnt !== 16'(LU_ST)) begin
            errors++;
            $display("FAIL lu_cnt: got %0d want %0d",
                     stall_cnt, LU_ST);
        end
    endtask

    task automatic test_back_to_back();
        logic e;
        do_reset();
        @(negedge clk);
        drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
        @(negedge clk);
        drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9);
        #1;
        checks++;
        if (pc_en !== 1'b1) begin
            errors++;
            $display("FAIL b2b_indep pc_en: got %b want 1", pc_en);
        end
        for (int c = 0; c <= B2B_ST; c++) begin
            @(negedge clk);
            drv(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
            #1;
            e = (c < B2B_ST);
            checks++;
            if ({pc_en, id_ex_bubble} !== {~e, e}) begin
                errors++;
                $display("FAIL b2b_cyc%0d: got %b want %b", c,
                         {pc_en, id_ex_bubble}, {~e, e});
            end
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (fwd_a !== FA_B2B || stall_cnt !== 16'(B2B_ST)) begin
            errors++;
            $display("FAIL b2b_fwd_cnt: got %b/%0d want %b/%0d",
                     fwd_a, stall_cnt, FA_B2B, B2B_ST);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        @(negedge clk);
        drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drv(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
            #1;
            checks++;
            if ({pc_en, id_ex_bubble} !== 2'b10) begin
                errors++;
                $display("FAIL zero_cyc%0d: got %b want 10", c,
                         {pc_en, id_ex_bubble});
            end
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if ({fwd_a, fwd_b} !== 4'b0000 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL zero_fwd_cnt: got %b/%0d want 0000/0",
                     {fwd_a, fwd_b}, stall_cnt);
        end
    endtask

    task automatic test_qualifiers();
        do_reset();
        @(negedge clk);
        drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7);
        @(negedge clk);
        drv(1'b1, 5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4);
        #1;
        checks++;
        if (pc_en !== 1'b1) begin
            errors++;
            $display("FAIL qual_rt_unused: got %b want 1", pc_en);
        end
        @(negedge clk);
        drv(1'b0, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9);
        #1;
        checks++;
        if (pc_en !== 1'b1) begin
            errors++;
            $display("FAIL qual_invalid: got %b want 1", pc_en);
        end
        do_reset();
        @(negedge clk);
        drv(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7);
        @(negedge clk);
        drv(1'b1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
        #1;
        checks++;
        if (pc_en !== 1'b1 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL qual_no_write: got %b/%0d want 1/0",
                     pc_en, stall_cnt);
        end
    endtask

    task automatic test_branch();
        do_reset();
        @(negedge clk);
        drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
        @(negedge clk);
        drv(1'b1, 5'd1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6);
        @(negedge clk);
        drv(1'b1, 5'd6, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7);
        #1;
        checks++;
        if (pc_en !== 1'b0) begin
            errors++;
            $display("FAIL br_pre_stall: got %b want 0", pc_en);
        end
        br_taken = 1'b1;
        #1;
        checks++;
        if ({pc_en, if_id_en, if_id_flush, id_ex_bubble,
             ex_mem_flush} !== 5'b11111) begin
            errors++;
            $display("FAIL br_taken: got %b want 11111",
                     {pc_en, if_id_en, if_id_flush,
                      id_ex_bubble, ex_mem_flush});
        end
        @(negedge clk);
        br_taken = 1'b0;
        drv(1'b1, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4);
        #1;
        checks++;
        if ({pc_en, if_id_en, if_id_flush, id_ex_bubble,
             ex_mem_flush} !== 5'b11000) begin
            errors++;
            $display("FAIL br_flush_cyc: got %b want 11000",
                     {pc_en, if_id_en, if_id_flush,
                      id_ex_bubble, ex_mem_flush});
        end
        @(negedge clk);
        drv(1'b1, 5'd4, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8);
        #1;
        checks++;
        if ({pc_en, if_id_en, if_id_flush, id_ex_bubble,
             ex_mem_flush} !== 5'b00010) begin
            errors++;
            $display("FAIL br_run_again: got %b want 00010",
                     {pc_en, if_id_en, if_id_flush,
                      id_ex_bubble, ex_mem_flush});
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL br_cnt: got %0d want 0", stall_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        @(negedge clk);
        drv(1'b1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
        @(negedge clk);
        drv(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
        @(negedge clk);
        drv(1'b1, 5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5);
        @(negedge clk);
        drv(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd6);
        #1;
        checks++;
        if ({pc_en, id_ex_bubble} !== 2'b01 ||
            stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL rms_pre: got %b/%0d want 01/1",
                     {pc_en, id_ex_bubble}, stall_cnt);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pc_en, if_id_en, if_id_flush, id_ex_bubble,
             ex_mem_flush, fwd_a, fwd_b} !== 9'b110000000 ||
            stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rms_async: got %b/%0d want 110000000/0",
                     {pc_en, if_id_en, if_id_flush, id_ex_bubble,
                      ex_mem_flush, fwd_a, fwd_b}, stall_cnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pc_en !== 1'b1 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rms_held: got %b/%0d want 1/0",
                     pc_en, stall_cnt);
        end
        @(negedge clk);
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_saturate();
        int cyc;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            drv(1'b1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
            cyc = 0;
            do begin
                @(negedge clk);
                drv(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
                #1;
                cyc++;
            end while (pc_en !== 1'b1 && cyc < 10);
            checks++;
            if (cyc >= 10) begin
                errors++;
                $display("FAIL sat_timeout: got %0d cycles want <10",
                         cyc);
            end
            if (p == 0) begin
                checks++;
                if (s_stall_cnt !== 2'(LU_ST)) begin
                    errors++;
                    $display("FAIL sat_first: got %0d want %0d",
                             s_stall_cnt, LU_ST);
                end
            end
            @(negedge clk);
            idle();
            @(negedge clk);
        end
        #1;
        checks++;
        if (stall_cnt !== 16'(4 * LU_ST) || s_stall_cnt !== 2'd3) begin
            errors++;
            $display("FAIL sat_final: got %0d/%0d want %0d/3",
                     stall_cnt, s_stall_cnt, 4 * LU_ST);
        end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_load_use();
        test_back_to_back();
        test_zero_reg();
        test_qualifiers();
        test_branch();
        test_reset_mid_stall();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
